// File: rtl/modem_pkg.sv
// modem_pkg: mode codes, sample format constants, demodulator states and the sine carrier table shared by the modem blocks
package modem_pkg;
  localparam logic [1:0] MOD_FSK = 2'd0;
  localparam logic [1:0] MOD_ASK = 2'd1;
  localparam logic [1:0] MOD_BPSK = 2'd2;
  localparam logic [1:0] MOD_QPSK = 2'd3;
  localparam int LUT_DEPTH = 64;
  localparam int PH_W = $clog2(LUT_DEPTH);
  localparam int SAMPLE_W = 16;
  localparam int MIDSCALE = 32768;
  typedef enum logic [1:0] {ST_IDLE, ST_INTEG, ST_FLUSH, ST_DECIDE} demod_state_t;
  // entry i = round(32767*sin(2*pi*i/64))
  localparam logic signed [SAMPLE_W-1:0] SIN_LUT [LUT_DEPTH] = '{
    16'sd0, 16'sd3212, 16'sd6393, 16'sd9512, 16'sd12539, 16'sd15446, 16'sd18204, 16'sd20787,
    16'sd23170, 16'sd25329, 16'sd27245, 16'sd28898, 16'sd30273, 16'sd31356, 16'sd32137, 16'sd32609,
    16'sd32767, 16'sd32609, 16'sd32137, 16'sd31356, 16'sd30273, 16'sd28898, 16'sd27245, 16'sd25329,
    16'sd23170, 16'sd20787, 16'sd18204, 16'sd15446, 16'sd12539, 16'sd9512, 16'sd6393, 16'sd3212,
    16'sd0, -16'sd3212, -16'sd6393, -16'sd9512, -16'sd12539, -16'sd15446, -16'sd18204, -16'sd20787,
    -16'sd23170, -16'sd25329, -16'sd27245, -16'sd28898, -16'sd30273, -16'sd31356, -16'sd32137, -16'sd32609,
    -16'sd32767, -16'sd32609, -16'sd32137, -16'sd31356, -16'sd30273, -16'sd28898, -16'sd27245, -16'sd25329,
    -16'sd23170, -16'sd20787, -16'sd18204, -16'sd15446, -16'sd12539, -16'sd9512, -16'sd6393, -16'sd3212
  };
endpackage

// File: rtl/carrier_ref_lut.sv
// carrier_ref_lut: registered signed sine reference addressed by carrier phase
module carrier_ref_lut import modem_pkg::*; (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PH_W-1:0]            phase,
  output logic signed [SAMPLE_W-1:0] sine
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sine <= '0;
    else sine <= SIN_LUT[phase];
endmodule

// File: rtl/bpsk_ask_demodulator.sv
// bpsk_ask_demodulator: coherent ASK/BPSK receiver; correlates samples with a sine reference over one symbol and slices the sum
module bpsk_ask_demodulator import modem_pkg::*; #(
  parameter int SYM_CYCLES = 256,
  parameter int ACC_W = 40,
  parameter logic signed [ACC_W-1:0] ASK_THR = 40'sd68719476736
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] din,
  input  logic [1:0]          mod,
  input  logic [1:0]          freq,
  input  logic                sym_start,
  output logic                dout,
  output logic                dout_valid,
  output logic                mode_err,
  output logic                busy
);
  localparam int CW = $clog2(SYM_CYCLES) + 1;
  demod_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, idx;
  logic [PH_W-1:0] phase, addr;
  logic [1:0] freq_q, f_eff;
  logic ask_q, ask_now, good, start_ok, take, last;
  logic signed [SAMPLE_W-1:0] s1, sine;
  logic signed [2*SAMPLE_W-1:0] prod;
  logic signed [ACC_W-1:0] acc, acc_n;
  logic v1, v2, f1, f2, l1, l2, a1, a2;
  carrier_ref_lut u_lut (.clk(clk), .rst_n(rst_n), .phase(addr), .sine(sine));
  // first/last/mode tags ride the pipeline so a new symbol can overlap the previous one's drain
  always_comb begin
    good = mod == MOD_ASK || mod == MOD_BPSK;
    start_ok = sym_start && good;
    take = start_ok || (state == ST_INTEG && !sym_start);
    idx = start_ok ? '0 : cnt;
    last = take && idx == CW'(SYM_CYCLES - 1);
    f_eff = sym_start ? freq : freq_q;
    ask_now = sym_start ? mod == MOD_ASK : ask_q;
    addr = start_ok ? '0 : phase;
    cnt_n = take ? idx + CW'(1) : (state == ST_FLUSH ? cnt + CW'(1) : cnt);
    state_n = start_ok ? ST_INTEG :
              sym_start ? ST_IDLE :
              last ? ST_FLUSH :
              (state == ST_FLUSH && cnt == CW'(SYM_CYCLES + 1)) ? ST_DECIDE :
              state == ST_DECIDE ? ST_IDLE : state;
    acc_n = v2 ? (f2 ? ACC_W'(0) : acc) + ACC_W'(prod) : acc;
  end
  assign busy = state != ST_IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE; cnt <= '0; phase <= '0; freq_q <= '0; ask_q <= 1'b0;
      s1 <= '0; prod <= '0; acc <= '0;
      v1 <= 1'b0; v2 <= 1'b0; f1 <= 1'b0; f2 <= 1'b0; l1 <= 1'b0; l2 <= 1'b0; a1 <= 1'b0; a2 <= 1'b0;
      dout <= 1'b0; dout_valid <= 1'b0; mode_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (take) phase <= addr + (PH_W'(1) << f_eff);
      if (sym_start) begin
        freq_q <= freq;
        ask_q <= mod == MOD_ASK;
      end
      mode_err <= mode_err || (sym_start && !good);
      s1 <= {~din[SAMPLE_W-1], din[SAMPLE_W-2:0]};
      v1 <= take; f1 <= start_ok; l1 <= last; a1 <= ask_now;
      prod <= s1 * sine;
      v2 <= v1; f2 <= f1; l2 <= l1; a2 <= a1;
      acc <= acc_n;
      dout_valid <= l2;
      if (l2) dout <= a2 ? acc_n > ASK_THR : acc_n > ACC_W'(0);
    end
endmodule
